// File: rtl/kmeans_iter_ctrl_if.sv
// Control bus between the K-Means iteration controller and its
// host, point RAM, argmin pipeline, accumulator and centroid updater.
interface kmeans_iter_ctrl_if #(
    parameter int LOG_DEPTH = 10,
    parameter int ITER_W    = 8
);
    logic                 start;
    logic [LOG_DEPTH:0]   npoints;
    logic [ITER_W-1:0]    max_iter;
    logic                 mem_rd;
    logic [LOG_DEPTH-1:0] mem_addr;
    logic                 accu_enable;
    logic                 accu_reset;
    logic                 update_start;
    logic                 update_done;
    logic                 changed;
    logic                 busy;
    logic                 done;
    logic [ITER_W-1:0]    iter_count;

    modport master (
        input  start, npoints, max_iter, update_done, changed,
        output mem_rd, mem_addr, accu_enable, accu_reset,
        output update_start, busy, done, iter_count
    );

    modport slave (
        output start, npoints, max_iter, update_done, changed,
        input  mem_rd, mem_addr, accu_enable, accu_reset,
        input  update_start, busy, done, iter_count
    );
endinterface

// File: rtl/kmeans_iter_ctrl.sv
// K-Means iteration sequencer: clear, stream points, drain the argmin
// pipeline, trigger centroid update, repeat until stable or limit.
module kmeans_iter_ctrl #(
    parameter int DEPTH     = 1024,
    parameter int LOG_DEPTH = 10,
    parameter int LAT       = 2,
    parameter int ITER_W    = 8
) (
    input logic              clk,
    input logic              rst,
    kmeans_iter_ctrl_if.master bus
);
    localparam int DW = $clog2(LAT + 2);
    localparam logic [LOG_DEPTH:0] NMAX = (LOG_DEPTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, CLEAR, STREAM, DRAIN, UPDATE, WAIT_UPD, FIN
    } state_t;

    state_t               r_state, w_next;
    logic [LOG_DEPTH:0]   r_npts, w_npts;
    logic [ITER_W-1:0]    r_max, w_max;
    logic [ITER_W-1:0]    r_iter, w_iter;
    logic [LOG_DEPTH-1:0] r_addr, w_addr;
    logic [DW-1:0]        r_dcnt, w_dcnt;
    logic [LAT:0]         r_vpipe;
    logic                 r_mem_rd;
    logic                 r_accu_reset;
    logic                 r_update_start;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_last;

    assign w_last = ({1'b0, r_addr} == r_npts - 1'b1);

    always_comb begin
        w_next = r_state;
        w_npts = r_npts;
        w_max  = r_max;
        w_iter = r_iter;
        w_addr = r_addr;
        w_dcnt = r_dcnt;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = CLEAR;
                    w_npts = (bus.npoints > NMAX) ? NMAX : bus.npoints;
                    w_max  = (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
                    w_iter = '0;
                end
            end
            CLEAR: begin
                w_addr = '0;
                w_next = (r_npts == '0) ? FIN : STREAM;
            end
            STREAM: begin
                if (w_last) begin
                    w_next = DRAIN;
                    w_dcnt = '0;
                end else begin
                    w_addr = r_addr + 1'b1;
                end
            end
            DRAIN: begin
                if (r_dcnt == DW'(LAT)) w_next = UPDATE;
                else w_dcnt = r_dcnt + 1'b1;
            end
            UPDATE: w_next = WAIT_UPD;
            WAIT_UPD: begin
                if (bus.update_done) begin
                    // limit is checked on the incremented value, so no wrap
                    w_iter = r_iter + 1'b1;
                    if (!bus.changed || w_iter == r_max) w_next = FIN;
                    else w_next = CLEAR;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_npts  <= '0;
            r_max   <= '0;
            r_iter  <= '0;
            r_addr  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_npts  <= w_npts;
            r_max   <= w_max;
            r_iter  <= w_iter;
            r_addr  <= w_addr;
            r_dcnt  <= w_dcnt;
        end
    end

    // outputs are decoded from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_rd       <= 1'b0;
            r_accu_reset   <= 1'b0;
            r_update_start <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_mem_rd       <= (w_next == STREAM);
            r_accu_reset   <= (w_next == CLEAR);
            r_update_start <= (w_next == UPDATE);
            r_done         <= (w_next == FIN);
            r_busy         <= (w_next inside {CLEAR, STREAM, DRAIN,
                                              UPDATE, WAIT_UPD});
        end
    end

    if (LAT == 0) begin : g_nolat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_vpipe <= '0;
            else r_vpipe <= r_mem_rd;
        end
    end else begin : g_lat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_vpipe <= '0;
            else r_vpipe <= {r_vpipe[LAT-1:0], r_mem_rd};
        end
    end

    assign bus.mem_rd       = r_mem_rd;
    assign bus.mem_addr     = r_addr;
    assign bus.accu_enable  = r_vpipe[LAT];
    assign bus.accu_reset   = r_accu_reset;
    assign bus.update_start = r_update_start;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.iter_count   = r_iter;
endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Directed bench for kmeans_iter_ctrl: cycle table for one short
// run plus sequences for long, empty, limit, ignored-start and reset cases.
module tb_kmeans_iter_ctrl;
    localparam int LOG_DEPTH = 10;
    localparam int ITER_W    = 8;
    localparam int LAT       = 2;
    localparam int DEPTH     = 1024;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    kmeans_iter_ctrl_if #(.LOG_DEPTH(LOG_DEPTH), .ITER_W(ITER_W)) bus();

    kmeans_iter_ctrl #(
        .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH), .LAT(LAT), .ITER_W(ITER_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, ud, ch;
        int rd, addr, en, ar, us, busy, done, iter;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(int st, int ud, int ch, int rd, int addr,
                                int en, int ar, int us, int busy,
                                int done, int iter);
        vec_t v;
        v.st = st; v.ud = ud; v.ch = ch;
        v.rd = rd; v.addr = addr; v.en = en; v.ar = ar;
        v.us = us; v.busy = busy; v.done = done; v.iter = iter;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string name, input int npts, input int maxit,
                           input int chg, input int dly, input int st_inj,
                           input int st_fin, input int exp_reads,
                           input int exp_ars, input int exp_uss,
                           input int exp_iter, output int maxaddr);
        int exp_addr = 0;
        int cnt = 0;
        int reads = 0, ens = 0, ars = 0, uss = 0, bad = 0;
        int iter = -1;
        int fin = 0;
        maxaddr = 0;
        bus.npoints     = (LOG_DEPTH + 1)'(npts);
        bus.max_iter    = ITER_W'(maxit);
        bus.changed     = chg[0];
        bus.update_done = 1'b0;
        bus.start       = 1'b1;
        tick();
        for (int c = 1; c < 20000 && fin == 0; c++) begin
            bus.start       = (c == st_inj);
            bus.update_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) bus.update_done = 1'b1;
            end
            if (bus.accu_reset) begin
                ars++;
                exp_addr = 0;
            end
            if (bus.mem_rd) begin
                reads++;
                if (int'(bus.mem_addr) != exp_addr) bad++;
                if (int'(bus.mem_addr) > maxaddr) maxaddr = int'(bus.mem_addr);
                exp_addr++;
            end
            if (bus.accu_enable) ens++;
            if (bus.accu_enable && bus.accu_reset) bad++;
            if (bus.update_start) begin
                uss++;
                cnt = dly;
            end
            if (bus.done) begin
                fin  = 1;
                iter = int'(bus.iter_count);
                if (bus.busy) bad++;
                if (st_fin != 0) bus.start = 1'b1;
            end else if (!bus.busy) begin
                bad++;
            end
            tick();
        end
        bus.start       = 1'b0;
        bus.update_done = 1'b0;
        chk({name, ".done_seen"}, fin, 1);
        chk({name, ".reads"}, reads, exp_reads);
        chk({name, ".enables"}, ens, exp_reads);
        chk({name, ".accu_resets"}, ars, exp_ars);
        chk({name, ".update_starts"}, uss, exp_uss);
        chk({name, ".iter_count"}, iter, exp_iter);
        chk({name, ".seq_violations"}, bad, 0);
    endtask

    initial begin
        int maxaddr;
        int found;
        int quiet;

        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 3, 1, 0, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.npoints     = '0;
        bus.max_iter    = '0;
        bus.update_done = 1'b0;
        bus.changed     = 1'b0;
        tick();
        tick();
        chk("rst.mem_rd", int'(bus.mem_rd), 0);
        chk("rst.mem_addr", int'(bus.mem_addr), 0);
        chk("rst.accu_enable", int'(bus.accu_enable), 0);
        chk("rst.accu_reset", int'(bus.accu_reset), 0);
        chk("rst.update_start", int'(bus.update_start), 0);
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        chk("rst.iter_count", int'(bus.iter_count), 0);
        rst = 1'b0;
        tick();

        // npoints=4, max_iter=8, updater answers changed=0 three cycles on
        bus.npoints  = 11'd4;
        bus.max_iter = 8'd8;
        for (int i = 0; i < 15; i++) begin
            bus.start       = tbl[i].st[0];
            bus.update_done = tbl[i].ud[0];
            bus.changed     = tbl[i].ch[0];
            chk($sformatf("t%0d.mem_rd", i), int'(bus.mem_rd), tbl[i].rd);
            if (tbl[i].rd != 0)
                chk($sformatf("t%0d.mem_addr", i), int'(bus.mem_addr),
                    tbl[i].addr);
            chk($sformatf("t%0d.accu_enable", i), int'(bus.accu_enable),
                tbl[i].en);
            chk($sformatf("t%0d.accu_reset", i), int'(bus.accu_reset),
                tbl[i].ar);
            chk($sformatf("t%0d.update_start", i), int'(bus.update_start),
                tbl[i].us);
            chk($sformatf("t%0d.busy", i), int'(bus.busy), tbl[i].busy);
            chk($sformatf("t%0d.done", i), int'(bus.done), tbl[i].done);
            chk($sformatf("t%0d.iter_count", i), int'(bus.iter_count),
                tbl[i].iter);
            tick();
        end
        bus.start       = 1'b0;
        bus.update_done = 1'b0;
        tick();

        run_job("full", 1024, 3, 1, 2, -1, 0, 3072, 3, 3, 3, maxaddr);
        chk("full.max_addr", maxaddr, 1023);
        tick();

        run_job("empty", 0, 5, 1, 2, -1, 0, 0, 1, 0, 0, maxaddr);
        tick();

        run_job("maxit0", 3, 0, 1, 2, -1, 0, 3, 1, 1, 1, maxaddr);
        tick();

        run_job("ignstart", 8, 2, 1, 1, 5, 1, 16, 2, 2, 2, maxaddr);
        quiet = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.busy || bus.accu_reset || bus.mem_rd) quiet++;
            tick();
        end
        chk("ignstart.idle_after", quiet, 0);

        // abort a run in the middle of streaming
        bus.npoints  = 11'd16;
        bus.max_iter = 8'd4;
        bus.changed  = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (bus.mem_rd && bus.mem_addr == 10'd5) found = 1;
            else tick();
        end
        chk("midrst.reached_read5", found, 1);
        rst = 1'b1;
        #1;
        chk("midrst.mem_rd", int'(bus.mem_rd), 0);
        chk("midrst.mem_addr", int'(bus.mem_addr), 0);
        chk("midrst.accu_enable", int'(bus.accu_enable), 0);
        chk("midrst.accu_reset", int'(bus.accu_reset), 0);
        chk("midrst.busy", int'(bus.busy), 0);
        chk("midrst.iter_count", int'(bus.iter_count), 0);
        tick();
        tick();
        rst = 1'b0;
        quiet = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.accu_enable || bus.busy || bus.mem_rd) quiet++;
            tick();
        end
        chk("midrst.no_enable_after", quiet, 0);
        run_job("afterrst", 16, 1, 1, 2, -1, 0, 16, 1, 1, 1, maxaddr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
